// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown sequencer: FSM state encodings and widths.
package countdown_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/countdown_ctrl_if.sv
// Board-side bundle: debounced buttons and chain status in, digit-chain controls out.
interface countdown_ctrl_if;
    import countdown_pkg::*;

    logic            start_btn;
    logic            pause_btn;
    logic            clear_btn;
    logic            chain_zero;
    logic            digit_ce;
    logic            digit_load;
    logic            digit_clear;
    logic            running;
    logic            done_led;
    logic [ST_W-1:0] state_o;

    modport slave (
        input  start_btn, pause_btn, clear_btn, chain_zero,
        output digit_ce, digit_load, digit_clear, running, done_led, state_o
    );

    modport master (
        output start_btn, pause_btn, clear_btn, chain_zero,
        input  digit_ce, digit_load, digit_clear, running, done_led, state_o
    );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter with hold (en low) and synchronous clear.
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] TC = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == TC);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = tick ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown sequencer: button sync/edge detect, start/pause/clear FSM and the
// registered strobes/levels that drive the cascaded digit chain.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    countdown_ctrl_if.slave   bus
);

    localparam int B_START = 0;
    localparam int B_PAUSE = 1;
    localparam int B_CLEAR = 2;

    logic [2:0] btn_raw, btn_evt;
    assign btn_raw = {bus.clear_btn, bus.pause_btn, bus.start_btn};

    // Each button: synchroniser chain, then one-cycle event on the synced rising edge.
    for (genvar g = 0; g < 3; g++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   prev_q, prev_d;

        always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw[g]};
            prev_d = sync_q[SYNC_STAGES-1];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
                prev_q <= 1'b0;
            end else begin
                sync_q <= sync_d;
                prev_q <= prev_d;
            end
        end

        assign btn_evt[g] = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    logic evt_start, evt_pause, evt_clear;
    assign evt_start = btn_evt[B_START];
    assign evt_pause = btn_evt[B_PAUSE];
    assign evt_clear = btn_evt[B_CLEAR];

    state_e state_q, state_d;
    logic   ce_q, ce_d;
    logic   load_q, load_d;
    logic   clr_q, clr_d;
    logic   run_q, run_d;
    logic   led_q, led_d;
    logic   pre_en, pre_clr, tick;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
        .clk   (clk),
        .reset (reset),
        .en    (pre_en),
        .clr   (pre_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        ce_d    = 1'b0;
        case (state_q)
            ST_IDLE:   if (!evt_clear && evt_start) state_d = ST_RUN;
            ST_RUN: begin
                // clear/pause beat the terminal count: no strobe that cycle
                if (evt_clear)      state_d = ST_IDLE;
                else if (evt_pause) state_d = ST_PAUSED;
                else if (tick) begin
                    if (bus.chain_zero) state_d = ST_DONE;
                    else                ce_d    = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (evt_clear)      state_d = ST_IDLE;
                else if (evt_pause) state_d = ST_RUN;
            end
            ST_DONE:   if (evt_clear || evt_start) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        pre_clr = (state_q == ST_IDLE && state_d == ST_RUN) ||
                  (state_q != ST_DONE && state_d == ST_DONE);
        pre_en  = (state_q == state_d) && (state_q == ST_RUN || state_q == ST_DONE);

        load_d = (state_d == ST_IDLE);
        clr_d  = (state_d == ST_DONE);
        run_d  = (state_d == ST_RUN);
        led_d  = (state_d == ST_DONE) && (led_q ^ (state_q == ST_DONE && tick));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ce_q    <= 1'b0;
            load_q  <= 1'b1;
            clr_q   <= 1'b0;
            run_q   <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ce_q    <= ce_d;
            load_q  <= load_d;
            clr_q   <= clr_d;
            run_q   <= run_d;
            led_q   <= led_d;
        end
    end

    assign bus.digit_ce    = ce_q;
    assign bus.digit_load  = load_q;
    assign bus.digit_clear = clr_q;
    assign bus.running     = run_q;
    assign bus.done_led    = led_q;
    assign bus.state_o     = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: 2-digit chain model plus a cycle-level behavioural
// reference, directed scenarios and a randomized button soak.
module tb_countdown_ctrl;

    localparam int TD = 4;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic reset;
    bit   force_zero;
    int   digits = 99;
    int   n_cmp = 0;
    int   n_bad = 0;

    countdown_ctrl_if bus();

    countdown_ctrl #(.TICK_DIV(TD), .SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Two-digit decimal chain: preset 99, forced 0, decremented by the strobe.
    always @(posedge clk) begin
        if (bus.digit_load)                 digits <= 99;
        else if (bus.digit_clear)           digits <= 0;
        else if (bus.digit_ce && digits > 0) digits <= digits - 1;
    end
    assign bus.chain_zero = (digits == 0) || force_zero;

    typedef struct {
        int        st;
        int        pre;
        bit        ce, load, clr, run, led;
        bit [SS:0] hs, hp, hc;
    } mdl_t;

    function automatic mdl_t mdl_rst();
        mdl_t r;
        r.st = 0; r.pre = 0; r.ce = 0; r.load = 1; r.clr = 0; r.run = 0; r.led = 0;
        r.hs = '0; r.hp = '0; r.hc = '0;
        return r;
    endfunction

    // One clock of the specified behaviour; states 0 idle, 1 run, 2 paused, 3 done.
    function automatic mdl_t step(mdl_t m, bit sb, bit pb, bit cb, bit cz);
        mdl_t n;
        bit es, ep, ec, tc;
        n  = m;
        es = m.hs[SS-1] & ~m.hs[SS];
        ep = m.hp[SS-1] & ~m.hp[SS];
        ec = m.hc[SS-1] & ~m.hc[SS];
        n.hs = {m.hs[SS-1:0], sb};
        n.hp = {m.hp[SS-1:0], pb};
        n.hc = {m.hc[SS-1:0], cb};
        tc   = (m.pre == TD - 1);
        n.ce = 0;
        if (ec) n.st = 0;
        else if (m.st == 0 && es) n.st = 1;
        else if (m.st == 1 && ep) n.st = 2;
        else if (m.st == 1 && tc) begin
            if (cz) n.st = 3;
            else    n.ce = 1;
        end
        else if (m.st == 2 && ep) n.st = 1;
        else if (m.st == 3 && es) n.st = 0;
        if ((m.st == 0 && n.st == 1) || (m.st != 3 && n.st == 3)) n.pre = 0;
        else if (m.st == n.st && (m.st == 1 || m.st == 3)) n.pre = (m.pre + 1) % TD;
        n.led  = (n.st == 3) ? ((m.st == 3 && tc) ? !m.led : m.led) : 1'b0;
        n.load = (n.st == 0);
        n.clr  = (n.st == 3);
        n.run  = (n.st == 1);
        return n;
    endfunction

    mdl_t m;
    always @(posedge clk or posedge reset) begin
        if (reset) m <= mdl_rst();
        else       m <= step(m, bus.start_btn, bus.pause_btn, bus.clear_btn, bus.chain_zero);
    end

    function automatic logic [6:0] exp_vec(mdl_t x);
        return {x.ce, x.load, x.clr, x.run, x.led, 2'(x.st)};
    endfunction

    wire [6:0] obs = {bus.digit_ce, bus.digit_load, bus.digit_clear, bus.running,
                      bus.done_led, bus.state_o};

    task automatic test_reset();
        int ces = 0;
        #2;
        n_cmp++;
        if (obs !== 7'b0100000) begin
            n_bad++; $display("FAIL reset_values: got %b want %b", obs, 7'b0100000);
        end
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_vec(m)) begin
                n_bad++; $display("FAIL idle_model cyc %0d: got %b want %b", i, obs, exp_vec(m));
            end
            if (bus.digit_ce) ces++;
        end
        n_cmp++;
        if (ces !== 0 || bus.state_o !== 2'd0 || bus.digit_load !== 1'b1) begin
            n_bad++; $display("FAIL idle_quiet: ce=%0d state=%0d load=%b want 0/0/1",
                              ces, bus.state_o, bus.digit_load);
        end
    endtask

    task automatic test_full_count();
        int strobes = 0, run_at = -1, first_ce = -1, cyc = 0, toggles = 0;
        bit done = 0, prev;
        bus.start_btn = 1'b1;
        while (!done && cyc < 600) begin
            @(negedge clk); cyc++;
            if (cyc == 1) bus.start_btn = 1'b0;
            n_cmp++;
            if (obs !== exp_vec(m)) begin
                n_bad++; $display("FAIL count_model cyc %0d: got %b want %b", cyc, obs, exp_vec(m));
            end
            if (run_at < 0 && bus.running) run_at = cyc;
            if (bus.digit_ce) begin
                strobes++;
                if (first_ce < 0) first_ce = cyc - run_at;
            end
            if (bus.state_o == 2'd3) done = 1;
        end
        n_cmp++;
        if (run_at !== 3) begin n_bad++; $display("FAIL start_latency: got %0d want 3", run_at); end
        n_cmp++;
        if (first_ce !== TD) begin n_bad++; $display("FAIL first_strobe: got %0d want %0d", first_ce, TD); end
        n_cmp++;
        if (strobes !== 99 || !done) begin
            n_bad++; $display("FAIL strobe_count: got %0d done=%0d want 99 done=1", strobes, done);
        end
        prev = bus.done_led;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_vec(m)) begin
                n_bad++; $display("FAIL done_model cyc %0d: got %b want %b", i, obs, exp_vec(m));
            end
            if (bus.done_led != prev) toggles++;
            prev = bus.done_led;
        end
        n_cmp++;
        if (toggles !== 4 || bus.digit_clear !== 1'b1 || bus.state_o !== 2'd3) begin
            n_bad++; $display("FAIL done_led: toggles=%0d clear=%b state=%0d want 4/1/3",
                              toggles, bus.digit_clear, bus.state_o);
        end
    endtask

    task automatic test_start_held();
        int saw_run = 0;
        bus.start_btn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_vec(m)) begin
                n_bad++; $display("FAIL held_model cyc %0d: got %b want %b", i, obs, exp_vec(m));
            end
            if (bus.running) saw_run++;
        end
        n_cmp++;
        if (saw_run !== 0 || bus.state_o !== 2'd0 || bus.digit_load !== 1'b1) begin
            n_bad++; $display("FAIL start_held: run=%0d state=%0d load=%b want 0/0/1",
                              saw_run, bus.state_o, bus.digit_load);
        end
        bus.start_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 5) bus.start_btn = 1'b1;
            if (i == 6) bus.start_btn = 1'b0;
            n_cmp++;
            if (obs !== exp_vec(m)) begin
                n_bad++; $display("FAIL rearm_model cyc %0d: got %b want %b", i, obs, exp_vec(m));
            end
        end
        n_cmp++;
        if (bus.running !== 1'b1) begin n_bad++; $display("FAIL rearm_run: got %b want 1", bus.running); end
    endtask

    task automatic test_pause();
        int k = 0, ces = 0, cyc = 0;
        while (!(m.st == 1 && m.pre == 0) && k < 20) begin @(negedge clk); k++; end
        n_cmp++;
        if (k >= 20) begin n_bad++; $display("FAIL pause_setup: got timeout want pre=0 in run"); end
        bus.pause_btn = 1'b1;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            bus.pause_btn = 1'b0;
            n_cmp++;
            if (obs !== exp_vec(m)) begin
                n_bad++; $display("FAIL pause_model cyc %0d: got %b want %b", i, obs, exp_vec(m));
            end
            if (i == 2 && bus.state_o !== 2'd2) begin
                n_bad++; $display("FAIL pause_enter: got %0d want 2", bus.state_o);
            end
            if (bus.digit_ce) ces++;
        end
        n_cmp++;
        if (ces !== 0) begin n_bad++; $display("FAIL pause_hold: got %0d strobes want 0", ces); end
        bus.pause_btn = 1'b1;
        k = 0;
        while (!bus.running && k < 10) begin @(negedge clk); bus.pause_btn = 1'b0; k++; end
        while (!bus.digit_ce && cyc < 10) begin
            @(negedge clk); cyc++;
            n_cmp++;
            if (obs !== exp_vec(m)) begin
                n_bad++; $display("FAIL resume_model cyc %0d: got %b want %b", cyc, obs, exp_vec(m));
            end
        end
        n_cmp++;
        if (cyc !== 2) begin n_bad++; $display("FAIL resume_strobe: got %0d want 2", cyc); end
    endtask

    task automatic test_clear_at_tc();
        int k = 0, ces = 0;
        while (!(m.st == 1 && m.pre == 1) && k < 20) begin @(negedge clk); k++; end
        bus.clear_btn = 1'b1; bus.pause_btn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.clear_btn = 1'b0; bus.pause_btn = 1'b0;
            n_cmp++;
            if (obs !== exp_vec(m)) begin
                n_bad++; $display("FAIL tc_clear_model cyc %0d: got %b want %b", i, obs, exp_vec(m));
            end
            if (bus.digit_ce) ces++;
        end
        n_cmp++;
        if (ces !== 0 || bus.state_o !== 2'd0 || bus.digit_load !== 1'b1 || k >= 20) begin
            n_bad++; $display("FAIL tc_clear: ce=%0d state=%0d load=%b want 0/0/1",
                              ces, bus.state_o, bus.digit_load);
        end
    endtask

    task automatic test_async_reset();
        bus.start_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start_btn = 1'b0;
        end
        n_cmp++;
        if (bus.running !== 1'b1) begin n_bad++; $display("FAIL rst_setup: got run=%b want 1", bus.running); end
        @(posedge clk); #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 7'b0100000) begin
            n_bad++; $display("FAIL async_reset: got %b want %b", obs, 7'b0100000);
        end
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_vec(m) || digits !== 99) begin
                n_bad++; $display("FAIL post_reset cyc %0d: got %b digits %0d want %b digits 99",
                                  i, obs, digits, exp_vec(m));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_vec(m)) begin
                n_bad++; $display("FAIL random_model cyc %0d: got %b want %b", i, obs, exp_vec(m));
            end
            if ($urandom_range(0, 11) == 0) bus.start_btn = ~bus.start_btn;
            if ($urandom_range(0, 15) == 0) bus.pause_btn = ~bus.pause_btn;
            if ($urandom_range(0, 79) == 0) bus.clear_btn = ~bus.clear_btn;
            force_zero = ($urandom_range(0, 9) == 0);
        end
        bus.start_btn = 1'b0; bus.pause_btn = 1'b0; bus.clear_btn = 1'b0; force_zero = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.start_btn = 1'b0;
        bus.pause_btn = 1'b0;
        bus.clear_btn = 1'b0;
        force_zero    = 1'b0;
        test_reset();
        test_full_count();
        test_start_held();
        test_pause();
        test_clear_at_tc();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
